// File: rtl/disp_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller with blanking gaps,
// double-buffered display data committed atomically at frame end.
module disp_scan_ctrl #(
   parameter int DIV   = 50000,
   parameter int BLANK = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic [15:0] data_in,
   input  logic [3:0]  point_in,
   input  logic [3:0]  en_in,
   input  logic        lzs,
   output logic [3:0]  AN,
   output logic [3:0]  Hex,
   output logic        LE,
   output logic        p,
   output logic        upd_done,
   output logic        pending
);

   typedef enum logic {ST_BLANK, ST_SHOW} state_t;

   localparam int MAXC = (DIV > BLANK) ? DIV : BLANK;
   localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

   state_t          state, state_nxt;
   logic [CW-1:0]   cnt, cnt_nxt;
   logic [1:0]      dig, dig_nxt;

   logic [15:0]     stg_data, disp_data;
   logic [3:0]      stg_point, disp_point;
   logic [3:0]      stg_en, disp_en;

   logic            frame_end;
   logic            commit;
   logic [3:0]      nib;
   logic            upper_zero;

   assign frame_end = (state == ST_SHOW) && (cnt == CW'(DIV - 1)) && (dig == 2'd3);
   assign commit    = frame_end && pending;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_BLANK;
         cnt   <= '0;
         dig   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         dig   <= dig_nxt;
      end
   end

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt + 1'b1;
      dig_nxt   = dig;
      case (state)
         ST_BLANK: begin
            if (cnt == CW'(BLANK - 1)) begin
               state_nxt = ST_SHOW;
               cnt_nxt   = '0;
            end
         end
         ST_SHOW: begin
            if (cnt == CW'(DIV - 1)) begin
               state_nxt = ST_BLANK;
               cnt_nxt   = '0;
               dig_nxt   = dig + 2'd1;
            end
         end
         default: begin
            state_nxt = ST_BLANK;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Staging absorbs loads at any time; display copies only at frame end so
   // a frame never mixes old and new data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stg_data   <= '0;
         stg_point  <= '0;
         stg_en     <= 4'hF;
         disp_data  <= '0;
         disp_point <= '0;
         disp_en    <= 4'hF;
         pending    <= 1'b0;
         upd_done   <= 1'b0;
      end else begin
         upd_done <= commit;
         pending  <= load | (pending & ~frame_end);
         if (commit) begin
            disp_data  <= stg_data;
            disp_point <= stg_point;
            disp_en    <= stg_en;
         end
         if (load) begin
            stg_data  <= data_in;
            stg_point <= point_in;
            stg_en    <= en_in;
         end
      end
   end

   assign nib        = disp_data[{dig, 2'b00} +: 4];
   assign upper_zero = (disp_data >> {dig, 2'b00}) == 16'h0000;

   always_comb begin
      AN  = 4'hF;
      Hex = nib;
      LE  = 1'b0;
      p   = 1'b0;
      if (state == ST_SHOW) begin
         AN = ~(4'b0001 << dig);
         p  = disp_point[dig];
         LE = disp_en[dig] && !(lzs && (dig != 2'd0) && upper_zero);
      end
   end

endmodule
